fifo_sync: RTL and testbench
============================

Name: fifo_sync

Overview:
- Single-clock, parametrised successor to the dual-clock FIFO, used where producer and consumer share a clock domain.
- Adds configurable data width and depth, standard or first-word-fall-through (FWFT) read mode, occupancy count, almost-full/almost-empty thresholds, and sticky oflow/uflow with software clear.
- Storage is a register array of 2**PTR_WIDTH entries with PTR_WIDTH+1-bit wrap-tagged pointers.

Parameters:
- DATA_WIDTH, 8, width of data_wr/data_rd in bits.
- PTR_WIDTH, 4, address width; DEPTH = 2**PTR_WIDTH entries.
- AFULL_THRESH, 2**PTR_WIDTH-2, almost_full asserted when count >= AFULL_THRESH.
- AEMPTY_THRESH, 2, almost_empty asserted when count <= AEMPTY_THRESH.
- FWFT, 0, 0 = standard read (data one cycle after rd_en); 1 = head word presented without a request.

Ports:
- aclk  in  1  clock, all logic on rising edge.
- aresetn  in  1  synchronous active-low reset.
- wr_en  in  1  write request.
- data_wr  in  DATA_WIDTH  write data, sampled when wr_en=1.
- rd_en  in  1  read request (standard) / pop (FWFT).
- data_rd  out  DATA_WIDTH  read data.
- rd_valid  out  1  data_rd valid.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_THRESH.
- almost_empty  out  1  count <= AEMPTY_THRESH.
- count  out  PTR_WIDTH+1  current occupancy, 0..DEPTH.
- oflow  out  1  sticky: write attempted while full and not accepted.
- uflow  out  1  sticky: read attempted while empty.
- clr_flags  in  1  clears oflow/uflow.

Behaviour:
- Reset (aresetn=0 at rising edge): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, oflow=uflow=0, rd_valid=0, data_rd=0 (standard mode). Memory contents not reset. Reset mid-operation discards all stored words; the first post-reset write is read first.
- Write accepted (wr_ok) when wr_en && (!full || rd_ok). Stores data_wr at mem[wr_ptr[PTR_WIDTH-1:0]]; wr_ptr increments, wrapping naturally at 2**(PTR_WIDTH+1).
- Read accepted (rd_ok) when rd_en && !empty. rd_ptr increments.
- count next = count + wr_ok - rd_ok. All flags are registered and derived from next count, so they are correct the cycle after the causing edge.
- Full with wr_en && rd_en: both accepted, count stays DEPTH, no oflow.
- Empty with wr_en && rd_en: write accepted, read rejected, uflow set, count becomes 1. No same-cycle bypass.
- Overflow: wr_en && full && !rd_en -> write dropped, data unchanged, oflow=1 next cycle.
- Underflow: rd_en && empty -> no pointer change, uflow=1 next cycle, rd_valid=0.
- clr_flags=1 clears both flags next cycle. A new overflow/underflow event in the same cycle wins, so the flag stays 1.
- Standard mode (FWFT=0):
  - rd_ok at edge N -> data_rd = mem[rd_ptr] and rd_valid=1 after edge N.
  - rd_valid is a one-cycle pulse per accepted read.
  - data_rd holds its last value otherwise.
- FWFT mode (FWFT=1):
  - data_rd = mem[rd_ptr] combinationally and rd_valid = !empty.
  - rd_en acts as acknowledge/pop; the next word appears after the pop edge.
  - A word written at edge N is visible with rd_valid=1 after edge N (write-to-read latency one cycle).
- Pointer full/empty check (equal low bits, differing/equal MSB) must agree with count at all times. Verification asserts this.

Test Plan:
- Reset then idle 5 cycles -> empty=1, almost_empty=1, full=0, count=0, oflow=uflow=0, rd_valid=0.
- DATA_WIDTH=8, PTR_WIDTH=4: write 0x00..0x0F on 16 consecutive cycles -> full=1 after 16th edge, almost_full=1 from count=14, count=16. Extra write 0xAA -> dropped, oflow=1. Then 16 reads -> 0x00..0x0F in order, each rd_valid one cycle after rd_en.
- Read while empty -> uflow=1, rd_valid=0. Assert clr_flags and rd_en on empty in the same cycle -> uflow stays 1. Next cycle clr_flags alone -> uflow=0.
- Fill to 16, then 20 cycles of simultaneous wr_en/rd_en with an incrementing pattern -> count stays 16, no oflow, output sequence continuous across pointer wrap.
- FWFT=1: write 0x5A -> next cycle rd_valid=1, data_rd=0x5A without rd_en. Pop -> empty=1, rd_valid=0.
- Write 7 words, deassert aresetn for 1 cycle, write 0x33 -> first read returns 0x33, count=1 before read.

Source files
------------

// File: rtl/fifo_sync.sv
// Single-clock FIFO with standard or first-word-fall-through read, occupancy
// count, almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module fifo_sync #(
  parameter int DATA_WIDTH    = 8,
  parameter int PTR_WIDTH     = 4,
  parameter int AFULL_THRESH  = 2**PTR_WIDTH - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 0
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_wr,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_rd,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [PTR_WIDTH:0]    count,
  output logic                  oflow,
  output logic                  uflow,
  input  logic                  clr_flags
);

  localparam int                 DEPTH    = 2**PTR_WIDTH;
  localparam logic [PTR_WIDTH:0] CNT_ONE  = (PTR_WIDTH+1)'(1);
  localparam logic [PTR_WIDTH:0] CNT_FULL = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH:0] CNT_AF   = (PTR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [PTR_WIDTH:0] CNT_AE   = (PTR_WIDTH+1)'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_WIDTH:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_WIDTH:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_WIDTH:0] count_reg, count_next;
  logic               full_reg, empty_reg;
  logic               afull_reg, aempty_reg;
  logic               oflow_reg, oflow_next;
  logic               uflow_reg, uflow_next;
  logic               wr_ok, rd_ok;

  logic [PTR_WIDTH-1:0] wr_addr, rd_addr;
  assign wr_addr = wr_ptr_reg[PTR_WIDTH-1:0];
  assign rd_addr = rd_ptr_reg[PTR_WIDTH-1:0];

  // A write into a full FIFO is still accepted when a read frees a slot on
  // the same edge; an empty FIFO never bypasses write data to the reader.
  assign rd_ok = rd_en && !empty_reg;
  assign wr_ok = wr_en && (!full_reg || rd_ok);

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (wr_ok) begin
      wr_ptr_next = wr_ptr_reg + CNT_ONE;
    end
    if (rd_ok) begin
      rd_ptr_next = rd_ptr_reg + CNT_ONE;
    end
    unique case ({wr_ok, rd_ok})
      2'b10:   count_next = count_reg + CNT_ONE;
      2'b01:   count_next = count_reg - CNT_ONE;
      default: count_next = count_reg;
    endcase
  end

  // A fresh event outranks a simultaneous clear so it is never lost.
  always_comb begin
    oflow_next = oflow_reg && !clr_flags;
    uflow_next = uflow_reg && !clr_flags;
    if (wr_en && full_reg && !rd_ok) begin
      oflow_next = 1'b1;
    end
    if (rd_en && empty_reg) begin
      uflow_next = 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (wr_ok) begin
      mem[wr_addr] <= data_wr;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
      afull_reg  <= 1'b0;
      aempty_reg <= 1'b1;
      oflow_reg  <= 1'b0;
      uflow_reg  <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      full_reg   <= (count_next == CNT_FULL);
      empty_reg  <= (count_next == '0);
      afull_reg  <= (count_next >= CNT_AF);
      aempty_reg <= (count_next <= CNT_AE);
      oflow_reg  <= oflow_next;
      uflow_reg  <= uflow_next;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is always on the bus; rd_en only pops it.
      assign data_rd  = mem[rd_addr];
      assign rd_valid = !empty_reg;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] data_rd_reg;
      logic                  rd_valid_reg;

      always_ff @(posedge aclk) begin
        if (!aresetn) begin
          data_rd_reg  <= '0;
          rd_valid_reg <= 1'b0;
        end else begin
          rd_valid_reg <= rd_ok;
          if (rd_ok) begin
            data_rd_reg <= mem[rd_addr];
          end
        end
      end

      assign data_rd  = data_rd_reg;
      assign rd_valid = rd_valid_reg;
    end
  endgenerate

  assign full         = full_reg;
  assign empty        = empty_reg;
  assign almost_full  = afull_reg;
  assign almost_empty = aempty_reg;
  assign count        = count_reg;
  assign oflow        = oflow_reg;
  assign uflow        = uflow_reg;

endmodule

// File: tb/tb_fifo_sync.sv
// Directed bench for fifo_sync: a standard-mode instance driven from a vector
// table plus hand sequences, and an FWFT instance for fall-through behaviour.
module tb_fifo_sync;

  logic       clk = 1'b0;
  logic       aresetn;
  logic       wr_en, rd_en, clr_flags;
  logic [7:0] data_wr;
  logic [7:0] data_rd;
  logic       rd_valid, full, empty, almost_full, almost_empty, oflow, uflow;
  logic [4:0] count;

  logic       f_wr_en, f_rd_en, f_clr_flags;
  logic [7:0] f_data_wr;
  logic [7:0] f_data_rd;
  logic       f_rd_valid, f_full, f_empty, f_almost_full, f_almost_empty, f_oflow, f_uflow;
  logic [4:0] f_count;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  fifo_sync #(.DATA_WIDTH(8), .PTR_WIDTH(4), .FWFT(0)) dut (
    .aclk(clk), .aresetn(aresetn), .wr_en(wr_en), .data_wr(data_wr),
    .rd_en(rd_en), .data_rd(data_rd), .rd_valid(rd_valid), .full(full),
    .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .oflow(oflow), .uflow(uflow), .clr_flags(clr_flags)
  );

  fifo_sync #(.DATA_WIDTH(8), .PTR_WIDTH(4), .FWFT(1)) dut_fwft (
    .aclk(clk), .aresetn(aresetn), .wr_en(f_wr_en), .data_wr(f_data_wr),
    .rd_en(f_rd_en), .data_rd(f_data_rd), .rd_valid(f_rd_valid), .full(f_full),
    .empty(f_empty), .almost_full(f_almost_full), .almost_empty(f_almost_empty),
    .count(f_count), .oflow(f_oflow), .uflow(f_uflow), .clr_flags(f_clr_flags)
  );

  typedef struct packed {
    logic       wr;
    logic [7:0] din;
    logic       rd;
    logic       clr;
    logic [4:0] cnt;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       of;
    logic       uf;
    logic       rv;
    logic       dchk;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic wr, logic [7:0] din, logic rd, logic clr,
                              int cnt, logic of, logic uf, logic rv,
                              logic dchk, logic [7:0] dout);
    vec_t v;
    v.wr = wr; v.din = din; v.rd = rd; v.clr = clr;
    v.cnt   = 5'(cnt);
    v.full  = (cnt == 16);
    v.empty = (cnt == 0);
    v.af    = (cnt >= 14);
    v.ae    = (cnt <= 2);
    v.of = of; v.uf = uf; v.rv = rv; v.dchk = dchk; v.dout = dout;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; rd_en = 1'b0; clr_flags = 1'b0; data_wr = 8'h00;
    f_wr_en = 1'b0; f_rd_en = 1'b0; f_clr_flags = 1'b0; f_data_wr = 8'h00;
  endtask

  // Flag outputs must always agree with the occupancy count.
  task automatic chk_consistency(input string tag);
    chk({tag, ".full_vs_count"},  {31'd0, full},  {31'd0, (count == 5'd16)});
    chk({tag, ".empty_vs_count"}, {31'd0, empty}, {31'd0, (count == 5'd0)});
  endtask

  initial begin
    idle_inputs();
    aresetn = 1'b0;
    tick();
    tick();
    aresetn = 1'b1;

    // Vector table: idle, fill, overflow, drain, underflow, flag clear.
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 8'h00));
    for (int i = 0; i < 16; i++) vecs.push_back(mk(1, 8'(i), 0, 0, i + 1, 0, 0, 0, 1, 8'h00));
    vecs.push_back(mk(1, 8'hAA, 0, 0, 16, 1, 0, 0, 1, 8'h00));
    for (int i = 0; i < 16; i++) vecs.push_back(mk(0, 8'h00, 1, 0, 15 - i, 1, 0, 1, 1, 8'(i)));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 1, 1, 0, 1, 8'h0F));
    vecs.push_back(mk(0, 8'h00, 1, 1, 0, 0, 1, 0, 1, 8'h0F));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 0, 1, 8'h0F));

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      string t;
      v = vecs[i];
      t = $sformatf("vec%0d", i);
      wr_en = v.wr; data_wr = v.din; rd_en = v.rd; clr_flags = v.clr;
      tick();
      chk({t, ".count"},        {27'd0, count},        {27'd0, v.cnt});
      chk({t, ".full"},         {31'd0, full},         {31'd0, v.full});
      chk({t, ".empty"},        {31'd0, empty},        {31'd0, v.empty});
      chk({t, ".almost_full"},  {31'd0, almost_full},  {31'd0, v.af});
      chk({t, ".almost_empty"}, {31'd0, almost_empty}, {31'd0, v.ae});
      chk({t, ".oflow"},        {31'd0, oflow},        {31'd0, v.of});
      chk({t, ".uflow"},        {31'd0, uflow},        {31'd0, v.uf});
      chk({t, ".rd_valid"},     {31'd0, rd_valid},     {31'd0, v.rv});
      if (v.dchk) chk({t, ".data_rd"}, {24'd0, data_rd}, {24'd0, v.dout});
      chk_consistency(t);
    end
    idle_inputs();
    $display("[TB] vector table done: %0d vectors", vecs.size());

    // Full FIFO with simultaneous read/write across pointer wrap.
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; data_wr = 8'(8'h10 + i);
      tick();
    end
    chk("wrap.fill_count", {27'd0, count}, 32'd16);
    for (int k = 0; k < 20; k++) begin
      wr_en = 1'b1; rd_en = 1'b1; data_wr = 8'(8'h20 + k);
      tick();
      chk($sformatf("wrap%0d.count", k), {27'd0, count}, 32'd16);
      chk($sformatf("wrap%0d.oflow", k), {31'd0, oflow}, 32'd0);
      chk($sformatf("wrap%0d.rd_valid", k), {31'd0, rd_valid}, 32'd1);
      chk($sformatf("wrap%0d.data_rd", k), {24'd0, data_rd},
          (k < 16) ? 32'(8'h10 + k) : 32'(8'h20 + k - 16));
      chk_consistency($sformatf("wrap%0d", k));
      $display("[TB] wrap cycle %0d data_rd=0x%02h", k, data_rd);
    end
    wr_en = 1'b0;
    for (int j = 0; j < 16; j++) begin
      rd_en = 1'b1;
      tick();
      chk($sformatf("drain%0d.data_rd", j), {24'd0, data_rd}, 32'(8'h24 + j));
      chk($sformatf("drain%0d.count", j), {27'd0, count}, 32'(15 - j));
    end
    idle_inputs();
    tick();
    chk("drain.empty", {31'd0, empty}, 32'd1);
    chk("drain.rd_valid_idle", {31'd0, rd_valid}, 32'd0);

    // Simultaneous write and read on empty: write taken, read rejected.
    wr_en = 1'b1; rd_en = 1'b1; data_wr = 8'h77;
    tick();
    chk("wr_rd_empty.count", {27'd0, count}, 32'd1);
    chk("wr_rd_empty.uflow", {31'd0, uflow}, 32'd1);
    chk("wr_rd_empty.rd_valid", {31'd0, rd_valid}, 32'd0);
    wr_en = 1'b0; rd_en = 1'b1; clr_flags = 1'b1;
    tick();
    chk("wr_rd_empty.read_data", {24'd0, data_rd}, 32'h77);
    chk("wr_rd_empty.read_valid", {31'd0, rd_valid}, 32'd1);
    chk("wr_rd_empty.uflow_clr", {31'd0, uflow}, 32'd0);
    idle_inputs();
    $display("[TB] empty write+read sequence done");

    // Reset mid-operation discards stored words.
    for (int i = 0; i < 7; i++) begin
      wr_en = 1'b1; data_wr = 8'(8'h40 + i);
      tick();
    end
    chk("midrst.pre_count", {27'd0, count}, 32'd7);
    wr_en = 1'b0; aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    chk("midrst.count", {27'd0, count}, 32'd0);
    chk("midrst.empty", {31'd0, empty}, 32'd1);
    chk("midrst.data_rd", {24'd0, data_rd}, 32'd0);
    wr_en = 1'b1; data_wr = 8'h33;
    tick();
    chk("midrst.count_after_wr", {27'd0, count}, 32'd1);
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    chk("midrst.first_read", {24'd0, data_rd}, 32'h33);
    chk("midrst.rd_valid", {31'd0, rd_valid}, 32'd1);
    chk("midrst.empty_after", {31'd0, empty}, 32'd1);
    idle_inputs();
    $display("[TB] mid-operation reset sequence done");

    // FWFT instance: head word shows up without a request.
    chk("fwft.reset_rd_valid", {31'd0, f_rd_valid}, 32'd0);
    f_wr_en = 1'b1; f_data_wr = 8'h5A;
    tick();
    chk("fwft.w1_rd_valid", {31'd0, f_rd_valid}, 32'd1);
    chk("fwft.w1_data", {24'd0, f_data_rd}, 32'h5A);
    chk("fwft.w1_count", {27'd0, f_count}, 32'd1);
    f_data_wr = 8'h6B;
    tick();
    f_wr_en = 1'b0;
    chk("fwft.w2_head_held", {24'd0, f_data_rd}, 32'h5A);
    chk("fwft.w2_count", {27'd0, f_count}, 32'd2);
    f_rd_en = 1'b1;
    tick();
    chk("fwft.pop1_data", {24'd0, f_data_rd}, 32'h6B);
    chk("fwft.pop1_rd_valid", {31'd0, f_rd_valid}, 32'd1);
    tick();
    f_rd_en = 1'b0;
    chk("fwft.pop2_empty", {31'd0, f_empty}, 32'd1);
    chk("fwft.pop2_rd_valid", {31'd0, f_rd_valid}, 32'd0);
    chk("fwft.full", {31'd0, f_full}, 32'd0);
    chk("fwft.almost_full", {31'd0, f_almost_full}, 32'd0);
    chk("fwft.almost_empty", {31'd0, f_almost_empty}, 32'd1);
    chk("fwft.oflow", {31'd0, f_oflow}, 32'd0);
    f_rd_en = 1'b1;
    tick();
    f_rd_en = 1'b0;
    chk("fwft.uflow", {31'd0, f_uflow}, 32'd1);
    chk("fwft.uflow_rd_valid", {31'd0, f_rd_valid}, 32'd0);
    $display("[TB] FWFT sequence done");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
